// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Groups the control and flow inputs of the program-counter sequencer together
// with the PC-side outputs that it returns.
//   master : driven by the controller / datapath. Drives the control and
//            operand fields, and reads back pc, pc_link, epc, pend_valid and
//            pc_misalign.
//   slave  : the sequencer itself.
// Signals
//   stall, beq_en, cmp_equal, imm_ext, jal_en, instr_index, jr_en, reg_jr,
//   exc_req, exc_pc, eret_en      : controller -> sequencer
//   pc, pc_link, epc, pend_valid,
//   pc_misalign                   : sequencer -> fetch / write-back / controller
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 26
);
  logic             stall;
  logic             beq_en;
  logic             cmp_equal;
  logic [WIDTH-1:0] imm_ext;
  logic             jal_en;
  logic [IDX_W-1:0] instr_index;
  logic             jr_en;
  logic [WIDTH-1:0] reg_jr;
  logic             exc_req;
  logic [WIDTH-1:0] exc_pc;
  logic             eret_en;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_link;
  logic [WIDTH-1:0] epc;
  logic             pend_valid;
  logic             pc_misalign;

  // Controller side: drives the flow controls and observes the PC outputs
  modport master (
    output stall, beq_en, cmp_equal, imm_ext, jal_en, instr_index,
           jr_en, reg_jr, exc_req, exc_pc, eret_en,
    input  pc, pc_link, epc, pend_valid, pc_misalign
  );

  // Sequencer side
  modport slave (
    input  stall, beq_en, cmp_equal, imm_ext, jal_en, instr_index,
           jr_en, reg_jr, exc_req, exc_pc, eret_en,
    output pc, pc_link, epc, pend_valid, pc_misalign
  );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Registered program-counter sequencer for the MIPS core. It owns the PC
// register and picks the next PC for sequential flow, beq, j/jal and jr. A
// stall holds the PC. A redirect that arrives during a stall is parked in a
// one-entry pending buffer and taken on the first unstalled edge. Exceptions
// jump to a fixed vector and save the faulting PC in EPC. eret returns to EPC.
// Ports
//   clk     : rising-edge clock
//   rst_n   : asynchronous reset, active low
//   seq_if  : pc_sequencer_if.slave
//             inputs  stall, beq_en, cmp_equal, imm_ext, jal_en, instr_index,
//                     jr_en, reg_jr, exc_req, exc_pc, eret_en
//             outputs pc (registered), pc_link (pc+4, comb), epc (registered),
//                     pend_valid (registered), pc_misalign (comb)
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int               WIDTH    = 32,
  parameter int               IDX_W    = 26,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  seq_if
);

  logic [WIDTH-1:0] pc_q,        pc_d;
  logic [WIDTH-1:0] epc_q,       epc_d;
  logic             pendValid_q, pendValid_d;
  logic [WIDTH-1:0] pendTgt_q,   pendTgt_d;

  logic [WIDTH-1:0] pcLink;
  logic [WIDTH-1:0] beqTgt;
  logic [WIDTH-1:0] jumpTgt;
  logic             redirValid;
  logic [WIDTH-1:0] redirTgt;

  // Sequential successor and the two PC-relative / region-relative targets.
  // The jump keeps the upper region bits of the current PC. All adds wrap
  // silently modulo 2^WIDTH.
  always_comb begin
    pcLink  = pc_q + WIDTH'(4);
    beqTgt  = pcLink + (seq_if.imm_ext << 2);
    jumpTgt = {pc_q[WIDTH-1:IDX_W+2], seq_if.instr_index, 2'b00};
  end

  // Non-exception redirect selection, with eret taking the highest priority
  // and jr the lowest. A beq with unequal operands is not a redirect.
  // Exceptions are handled separately in the next-state logic because they
  // also override stall.
  always_comb begin
    redirValid = 1'b1;
    redirTgt   = '0;
    if (seq_if.eret_en) begin
      redirTgt = epc_q;
    end else if (seq_if.beq_en && seq_if.cmp_equal) begin
      redirTgt = beqTgt;
    end else if (seq_if.jal_en) begin
      redirTgt = jumpTgt;
    end else if (seq_if.jr_en) begin
      redirTgt = seq_if.reg_jr;
    end else begin
      redirValid = 1'b0;
    end
  end

  // Next-state for PC, EPC and the pending-redirect buffer.
  // An exception beats everything, including stall. A stall with a redirect
  // parks that redirect and overwrites any older parked one. When unstalled,
  // a fresh redirect beats the parked one; otherwise the parked target is
  // consumed. Only then does the PC advance sequentially.
  always_comb begin
    pc_d        = pc_q;
    epc_d       = epc_q;
    pendValid_d = pendValid_q;
    pendTgt_d   = pendTgt_q;
    if (seq_if.exc_req) begin
      pc_d        = EXC_VEC;
      epc_d       = seq_if.exc_pc;
      pendValid_d = 1'b0;
    end else if (seq_if.stall) begin
      if (redirValid) begin
        pendTgt_d   = redirTgt;
        pendValid_d = 1'b1;
      end
    end else if (redirValid) begin
      pc_d        = redirTgt;
      pendValid_d = 1'b0;
    end else if (pendValid_q) begin
      pc_d        = pendTgt_q;
      pendValid_d = 1'b0;
    end else begin
      pc_d = pcLink;
    end
  end

  // State registers. The reset is asynchronous, so a reset during a stall or
  // with a parked redirect clears everything without waiting for an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      epc_q       <= '0;
      pendValid_q <= 1'b0;
      pendTgt_q   <= '0;
    end else begin
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      pendValid_q <= pendValid_d;
      pendTgt_q   <= pendTgt_d;
    end
  end

  // Outputs. A misaligned jr target is loaded as given. Raising the
  // resulting exception from pc_misalign is the controller's job.
  always_comb begin
    seq_if.pc          = pc_q;
    seq_if.pc_link     = pcLink;
    seq_if.epc         = epc_q;
    seq_if.pend_valid  = pendValid_q;
    seq_if.pc_misalign = (pc_q[1:0] != 2'b00);
  end

endmodule
